// File: rtl/din_feeder_pkg.sv
// Shared types and sizing helpers for the burst feeder and its FIFO.
package din_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } feeder_state_t;

    // Occupancy needs one extra bit so a completely full FIFO is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/din_sync_fifo.sv
// Single-clock FIFO with a combinational head-of-queue read and occupancy count.
module din_sync_fifo
    import din_feeder_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            push,
    input  logic                            pop,
    input  logic [DWIDTH-1:0]               wdata,
    output logic [DWIDTH-1:0]               rdata,
    output logic [count_width(DEPTH)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     count_reg;

    // Storage carries no reset so it can map onto distributed/block memory.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rdata = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/din_burst_feeder.sv
// Buffers upstream words and replays them to a non-stallable sink as paced bursts.
module din_burst_feeder
    import din_feeder_pkg::*;
#(
    parameter int DWIDTH    = 16,
    parameter int DEPTH     = 16,
    parameter int BURST_LEN = 4,
    parameter int GAP       = 3,
    parameter int TIMEOUT   = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        up_valid,
    output logic                        up_ready,
    input  logic [DWIDTH-1:0]           up_data,
    output logic                        din_valid,
    output logic [DWIDTH-1:0]           din_data,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        burst_active
);

    localparam int CW = count_width(DEPTH);
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    feeder_state_t     state_reg, state_next;
    logic [CW-1:0]     beats_reg, beats_next;
    logic [CW-1:0]     beat_cnt_reg, beat_cnt_next;
    logic [GW-1:0]     gap_cnt_reg, gap_cnt_next;
    logic [WW-1:0]     wait_cnt_reg, wait_cnt_next;
    logic              din_valid_reg, din_valid_next;
    logic [DWIDTH-1:0] din_data_reg, din_data_next;

    logic              push;
    logic              pop;
    logic [DWIDTH-1:0] fifo_head;
    logic [CW-1:0]     level_w;

    // Ready comes from the registered count only, so a same-cycle pop never frees a slot early.
    assign up_ready = (level_w < CW'(DEPTH));
    assign push     = up_valid && up_ready;

    din_sync_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (up_data),
        .rdata (fifo_head),
        .count (level_w)
    );

    always_comb begin
        state_next     = state_reg;
        beats_next     = beats_reg;
        beat_cnt_next  = beat_cnt_reg;
        gap_cnt_next   = gap_cnt_reg;
        wait_cnt_next  = wait_cnt_reg;
        din_valid_next = 1'b0;
        din_data_next  = din_data_reg;
        pop            = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (level_w >= CW'(BURST_LEN)) begin
                    beats_next    = CW'(BURST_LEN);
                    beat_cnt_next = '0;
                    wait_cnt_next = '0;
                    state_next    = ST_BURST;
                end else if ((TIMEOUT > 0) && (level_w != '0) &&
                             (wait_cnt_reg == WW'(TIMEOUT - 1))) begin
                    beats_next    = level_w;
                    beat_cnt_next = '0;
                    wait_cnt_next = '0;
                    state_next    = ST_BURST;
                end else if (level_w == '0) begin
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WW'(1);
                end
            end

            ST_BURST: begin
                // beats never exceeds the level seen at start, so the FIFO cannot run dry here.
                pop            = 1'b1;
                din_valid_next = 1'b1;
                din_data_next  = fifo_head;
                if (beat_cnt_reg == beats_reg - CW'(1)) begin
                    beat_cnt_next = '0;
                    gap_cnt_next  = '0;
                    state_next    = (GAP > 0) ? ST_GAP : ST_IDLE;
                end else begin
                    beat_cnt_next = beat_cnt_reg + CW'(1);
                end
            end

            ST_GAP: begin
                if (gap_cnt_reg == GW'(GAP - 1)) begin
                    gap_cnt_next = '0;
                    state_next   = ST_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GW'(1);
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            beats_reg     <= '0;
            beat_cnt_reg  <= '0;
            gap_cnt_reg   <= '0;
            wait_cnt_reg  <= '0;
            din_valid_reg <= 1'b0;
            din_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            beats_reg     <= beats_next;
            beat_cnt_reg  <= beat_cnt_next;
            gap_cnt_reg   <= gap_cnt_next;
            wait_cnt_reg  <= wait_cnt_next;
            din_valid_reg <= din_valid_next;
            din_data_reg  <= din_data_next;
        end
    end

    assign din_valid    = din_valid_reg;
    assign din_data     = din_data_reg;
    assign level        = level_w;
    assign burst_active = (state_reg == ST_BURST);

endmodule

// File: tb/tb_din_burst_feeder.sv
// Directed bench for din_burst_feeder: reset, full/partial bursts, backpressure, mid-burst reset.
module tb_din_burst_feeder;

    localparam int DWIDTH  = 16;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              up_valid;
    logic              up_ready;
    logic [DWIDTH-1:0] up_data;
    logic              din_valid;
    logic [DWIDTH-1:0] din_data;
    logic [4:0]        level;
    logic              burst_active;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    int log_data[$];
    int log_cyc[$];

    din_burst_feeder #(
        .DWIDTH    (DWIDTH),
        .DEPTH     (16),
        .BURST_LEN (4),
        .GAP       (3),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .up_valid     (up_valid),
        .up_ready     (up_ready),
        .up_data      (up_data),
        .din_valid    (din_valid),
        .din_data     (din_data),
        .level        (level),
        .burst_active (burst_active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Record every sink transfer with the cycle it occurred in.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && din_valid === 1'b1) begin
            log_data.push_back(int'(din_data));
            log_cyc.push_back(cyc);
            $display("[TB] cyc %0d din_data=0x%04h level=%0d", cyc, din_data, level);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_data.delete();
        log_cyc.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        up_valid = 1'b0;
        up_data = '0;
        repeat (3) tick();
        tests_run++; if (din_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_din_valid got %b want 0", din_valid); end
        tests_run++; if (din_data !== 16'h0000) begin tests_failed++; $display("FAIL reset_din_data got %h want 0000", din_data); end
        tests_run++; if (level !== 5'd0) begin tests_failed++; $display("FAIL reset_level got %0d want 0", level); end
        tests_run++; if (up_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_up_ready got %b want 1", up_ready); end
        tests_run++; if (burst_active !== 1'b0) begin tests_failed++; $display("FAIL reset_burst_active got %b want 0", burst_active); end
        rst_n = 1'b1;
        clear_log();
        repeat (50) tick();
        tests_run++; if (log_data.size() != 0) begin tests_failed++; $display("FAIL reset_idle_quiet got %0d beats want 0", log_data.size()); end
        tests_run++; if (level !== 5'd0) begin tests_failed++; $display("FAIL reset_idle_level got %0d want 0", level); end
    endtask

    task automatic test_full_burst();
        clear_log();
        for (int i = 1; i <= 4; i++) begin
            up_valid = 1'b1;
            up_data = 16'(i);
            tick();
        end
        up_valid = 1'b0;
        repeat (30) tick();
        tests_run++; if (log_data.size() != 4) begin tests_failed++; $display("FAIL full_burst_len got %0d want 4", log_data.size()); end
        for (int i = 0; i < log_data.size() && i < 4; i++) begin
            tests_run++; if (log_data[i] != i + 1) begin tests_failed++; $display("FAIL full_burst_data[%0d] got %0h want %0h", i, log_data[i], i + 1); end
            if (i > 0) begin
                tests_run++; if (log_cyc[i] != log_cyc[i-1] + 1) begin tests_failed++; $display("FAIL full_burst_contig[%0d] got cyc %0d want %0d", i, log_cyc[i], log_cyc[i-1] + 1); end
            end
        end
        tests_run++; if (level !== 5'd0 || burst_active !== 1'b0) begin tests_failed++; $display("FAIL full_burst_end got level=%0d active=%b want 0/0", level, burst_active); end
    endtask

    task automatic test_fill_backpressure();
        int next_word = 0;
        int max_level = 0;
        bit saw_not_ready = 0;
        bit acc;
        int n = 0;
        clear_log();
        up_valid = 1'b1;
        while (n < 200 || (next_word % 4) != 0) begin
            up_data = 16'(next_word);
            acc = up_ready;
            tick();
            if (acc) next_word++;
            if (int'(level) > max_level) max_level = int'(level);
            if (up_ready === 1'b0) saw_not_ready = 1;
            n++;
        end
        up_valid = 1'b0;
        repeat (200) tick();
        tests_run++; if (max_level != 16) begin tests_failed++; $display("FAIL fill_max_level got %0d want 16", max_level); end
        tests_run++; if (!saw_not_ready) begin tests_failed++; $display("FAIL fill_up_ready_drop got never-low want low-at-full"); end
        tests_run++; if (log_data.size() != next_word) begin tests_failed++; $display("FAIL fill_count got %0d want %0d", log_data.size(), next_word); end
        for (int i = 0; i < log_data.size() && i < next_word; i++) begin
            tests_run++; if (log_data[i] != i) begin tests_failed++; $display("FAIL fill_order[%0d] got %0h want %0h", i, log_data[i], i); end
            if (i % 4 != 0) begin
                tests_run++; if (log_cyc[i] != log_cyc[i-1] + 1) begin tests_failed++; $display("FAIL fill_burst_contig[%0d] got cyc %0d want %0d", i, log_cyc[i], log_cyc[i-1] + 1); end
            end else if (i > 0) begin
                tests_run++; if (log_cyc[i] - log_cyc[i-1] < 5) begin tests_failed++; $display("FAIL fill_gap[%0d] got spacing %0d want >=5", i, log_cyc[i] - log_cyc[i-1]); end
            end
        end
        tests_run++; if (level !== 5'd0) begin tests_failed++; $display("FAIL fill_drain_level got %0d want 0", level); end
    endtask

    task automatic test_partial_timeout();
        int k;
        clear_log();
        up_valid = 1'b1;
        up_data = 16'hA5A5;
        tick();
        k = cyc;
        tests_run++; if (level !== 5'd1) begin tests_failed++; $display("FAIL partial_level1 got %0d want 1", level); end
        up_data = 16'h5A5A;
        tick();
        up_valid = 1'b0;
        repeat (30) tick();
        tests_run++; if (log_data.size() != 2) begin tests_failed++; $display("FAIL partial_len got %0d want 2", log_data.size()); end
        if (log_data.size() >= 2) begin
            tests_run++; if (log_data[0] != 'hA5A5) begin tests_failed++; $display("FAIL partial_data0 got %0h want a5a5", log_data[0]); end
            tests_run++; if (log_data[1] != 'h5A5A) begin tests_failed++; $display("FAIL partial_data1 got %0h want 5a5a", log_data[1]); end
            tests_run++; if (log_cyc[0] != k + TIMEOUT + 1) begin tests_failed++; $display("FAIL partial_latency got cyc %0d want %0d", log_cyc[0], k + TIMEOUT + 1); end
            tests_run++; if (log_cyc[1] != log_cyc[0] + 1) begin tests_failed++; $display("FAIL partial_contig got cyc %0d want %0d", log_cyc[1], log_cyc[0] + 1); end
        end
        tests_run++; if (level !== 5'd0 || burst_active !== 1'b0) begin tests_failed++; $display("FAIL partial_end got level=%0d active=%b want 0/0", level, burst_active); end
    endtask

    task automatic test_simultaneous();
        int next_word = 0;
        int n = 0;
        bit acc;
        bit found = 0;
        clear_log();
        up_valid = 1'b1;
        while (n < 300 && !found) begin
            up_data = 16'(16'h0100 + next_word);
            acc = up_ready;
            tick();
            if (acc) next_word++;
            if (level === 5'd16 && burst_active === 1'b1) found = 1;
            n++;
        end
        tests_run++; if (!found) begin tests_failed++; $display("FAIL simul_reach_full_burst got timeout want level16+burst"); end
        if (found) begin
            up_data = 16'(16'h0100 + next_word);
            tests_run++; if (up_ready !== 1'b0) begin tests_failed++; $display("FAIL simul_ready_at_full got %b want 0", up_ready); end
            acc = up_ready;
            tick();
            if (acc) next_word++;
            tests_run++; if (level !== 5'd15) begin tests_failed++; $display("FAIL simul_level_after_pop got %0d want 15", level); end
            tests_run++; if (up_ready !== 1'b1 || burst_active !== 1'b1) begin tests_failed++; $display("FAIL simul_ready_next got ready=%b active=%b want 1/1", up_ready, burst_active); end
            up_data = 16'(16'h0100 + next_word);
            acc = up_ready;
            tick();
            if (acc) next_word++;
            tests_run++; if (level !== 5'd15) begin tests_failed++; $display("FAIL simul_level_push_pop got %0d want 15", level); end
        end
        while ((next_word % 4) != 0) begin
            up_data = 16'(16'h0100 + next_word);
            acc = up_ready;
            tick();
            if (acc) next_word++;
        end
        up_valid = 1'b0;
        repeat (120) tick();
        tests_run++; if (log_data.size() != next_word) begin tests_failed++; $display("FAIL simul_count got %0d want %0d", log_data.size(), next_word); end
        for (int i = 0; i < log_data.size() && i < next_word; i++) begin
            tests_run++; if (log_data[i] != 'h100 + i) begin tests_failed++; $display("FAIL simul_order[%0d] got %0h want %0h", i, log_data[i], 'h100 + i); end
        end
    endtask

    task automatic test_reset_mid_burst();
        int n = 0;
        clear_log();
        for (int i = 0; i < 4; i++) begin
            up_valid = 1'b1;
            up_data = 16'(16'h0020 + i);
            tick();
        end
        up_valid = 1'b0;
        while (din_valid !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        tests_run++; if (din_valid !== 1'b1) begin tests_failed++; $display("FAIL midrst_first_beat got timeout want din_valid"); end
        tick();
        tests_run++; if (din_valid !== 1'b1 || din_data !== 16'h0021) begin tests_failed++; $display("FAIL midrst_second_beat got v=%b d=%h want 1/0021", din_valid, din_data); end
        rst_n = 1'b0;
        #1;
        tests_run++; if (din_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_valid_drop got %b want 0", din_valid); end
        tests_run++; if (level !== 5'd0 || burst_active !== 1'b0 || up_ready !== 1'b1) begin tests_failed++; $display("FAIL midrst_state got level=%0d active=%b ready=%b want 0/0/1", level, burst_active, up_ready); end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        clear_log();
        for (int i = 0; i < 4; i++) begin
            up_valid = 1'b1;
            up_data = 16'(16'h0010 + i);
            tick();
        end
        up_valid = 1'b0;
        repeat (30) tick();
        tests_run++; if (log_data.size() != 4) begin tests_failed++; $display("FAIL midrst_after_len got %0d want 4", log_data.size()); end
        for (int i = 0; i < log_data.size() && i < 4; i++) begin
            tests_run++; if (log_data[i] != 'h10 + i) begin tests_failed++; $display("FAIL midrst_after_data[%0d] got %0h want %0h", i, log_data[i], 'h10 + i); end
            if (i > 0) begin
                tests_run++; if (log_cyc[i] != log_cyc[i-1] + 1) begin tests_failed++; $display("FAIL midrst_after_contig[%0d] got cyc %0d want %0d", i, log_cyc[i], log_cyc[i-1] + 1); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_burst();
        test_fill_backpressure();
        test_partial_timeout();
        test_simultaneous();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
